wall_bounce_engine: RTL

- Multi-ball successor to the single-ball wall collision checker.
- Once per frame, on a frame_start strobe, it scans NUM_BALLS balls sequentially, one ball per clk, through a 2-stage pipeline.
- For each ball it detects cushion hits per axis, with per-ball per-axis cooldown; reflects and damps the speed (restitution); and optionally detects pockets.
- Results stream out indexed by ball to the physics/friction stage.

---
 rtl/pool_pkg.sv | 44 ++++
 rtl/wall_axis_reflect.sv | 48 ++++
 rtl/wall_bounce_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared pool-table constants, FSM state type and small helpers used by the
// wall bounce engine and its per-axis reflect unit.
package pool_pkg;

  localparam int SPEED_W          = 11;
  localparam int DEF_RADIUS       = 16;
  localparam int DEF_TABLE_WIDTH  = 800;
  localparam int DEF_TABLE_HEIGHT = 600;
  localparam int DEF_POCKET_R     = 24;
  localparam int NUM_POCKETS      = 6;

  // Pocket centres for the default table: three along the top cushion,
  // three along the bottom cushion.
  localparam int POCKET_CX [NUM_POCKETS] = '{0, DEF_TABLE_WIDTH / 2, DEF_TABLE_WIDTH,
                                             0, DEF_TABLE_WIDTH / 2, DEF_TABLE_WIDTH};
  localparam int POCKET_CY [NUM_POCKETS] = '{0, 0, 0,
                                             DEF_TABLE_HEIGHT, DEF_TABLE_HEIGHT, DEF_TABLE_HEIGHT};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Bits needed to hold a cooldown count of 0..cooldown.
  function automatic int cooldown_w(input int cooldown);
    return $clog2(cooldown + 1);
  endfunction

  // Pocket centre x for an arbitrary table width (k = 0..5).
  function automatic int pocket_cx(input int k, input int table_width);
    case (k % 3)
      0:       return 0;
      1:       return table_width / 2;
      default: return table_width;
    endcase
  endfunction

  // Pocket centre y for an arbitrary table height (k = 0..5).
  function automatic int pocket_cy(input int k, input int table_height);
    return (k < 3) ? 0 : table_height;
  endfunction

endpackage

// File: rtl/wall_axis_reflect.sv
// One-axis cushion hit test with saturated reflection and restitution damping.
// Purely combinational; instantiated once per axis by the engine.
module wall_axis_reflect
  import pool_pkg::*;
#(
  parameter int W          = SPEED_W,
  parameter int RADIUS     = DEF_RADIUS,
  parameter int LIMIT      = DEF_TABLE_WIDTH,
  parameter int DAMP_SHIFT = 3
) (
  input  logic signed [W-1:0] pos,
  input  logic signed [W-1:0] spd,
  input  logic                blocked,
  output logic                hit,
  output logic signed [W-1:0] spd_new
);

  localparam logic signed [W:0]   LO_LIM = (W+1)'(RADIUS);
  localparam logic signed [W:0]   HI_LIM = (W+1)'(LIMIT - RADIUS);
  localparam logic signed [W-1:0] S_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN  = {1'b1, {(W-1){1'b0}}};

  // Negation that cannot overflow: the most negative speed maps to +max.
  function automatic logic signed [W-1:0] sat_negate(input logic signed [W-1:0] v);
    if (v == S_MIN) return S_MAX;
    return -v;
  endfunction

  // Restitution: remove 1/2^DAMP_SHIFT of the speed (floor shift), or pass through.
  function automatic logic signed [W-1:0] damp(input logic signed [W-1:0] v);
    if (DAMP_SHIFT == 0) return v;
    return v - (v >>> DAMP_SHIFT);
  endfunction

  logic signed [W:0] nxt;
  logic              toward_lo;
  logic              toward_hi;

  // Next position one bit wider so it cannot wrap; hit only when moving into the cushion.
  always_comb begin
    nxt       = {pos[W-1], pos} + {spd[W-1], spd};
    toward_lo = spd[W-1] || (spd == '0);
    toward_hi = !spd[W-1];
    hit       = !blocked && (((nxt < LO_LIM) && toward_lo) || ((nxt > HI_LIM) && toward_hi));
    spd_new   = hit ? damp(sat_negate(spd)) : spd;
  end

endmodule

// File: rtl/wall_bounce_engine.sv
// Multi-ball cushion/pocket engine: on frame_start scans every ball once, one
// per clock, and streams reflected/damped speeds indexed by ball.
module wall_bounce_engine
  import pool_pkg::*;
#(
  parameter int NUM_BALLS    = 16,
  parameter int W            = SPEED_W,
  parameter int RADIUS       = DEF_RADIUS,
  parameter int TABLE_WIDTH  = DEF_TABLE_WIDTH,
  parameter int TABLE_HEIGHT = DEF_TABLE_HEIGHT,
  parameter int COOLDOWN     = 5,
  parameter int DAMP_SHIFT   = 3,
  parameter int POCKET_EN    = 1,
  parameter int POCKET_R     = DEF_POCKET_R
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_BALLS*W-1:0]       x_all,
  input  logic [NUM_BALLS*W-1:0]       y_all,
  input  logic [NUM_BALLS*W-1:0]       xs_all,
  input  logic [NUM_BALLS*W-1:0]       ys_all,
  output logic                         out_valid,
  output logic [$clog2(NUM_BALLS)-1:0] out_idx,
  output logic signed [W-1:0]          out_xspeed,
  output logic signed [W-1:0]          out_yspeed,
  output logic [1:0]                   out_collision,
  output logic                         out_pocket,
  output logic                         busy,
  output logic                         done
);

  localparam int                   IW       = $clog2(NUM_BALLS);
  localparam int                   CW       = cooldown_w(COOLDOWN);
  localparam logic [CW-1:0]        CD_MAX   = CW'(COOLDOWN);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_BALLS - 1);
  localparam logic signed [W+1:0]  PR_S     = (W+2)'(POCKET_R);

  scan_state_t   state;
  scan_state_t   state_nxt;
  logic          issue;
  logic [IW-1:0] idx_p0;

  logic [CW-1:0] cd_x [NUM_BALLS];
  logic [CW-1:0] cd_y [NUM_BALLS];

  logic signed [W-1:0] x_p0, y_p0, xs_p0, ys_p0;
  logic signed [W-1:0] xsn_p0, ysn_p0;
  logic [CW-1:0]       cdx_p0, cdy_p0;
  logic                hitx_p0, hity_p0;
  logic                pocket_p0;
  int                  sel_p0;

  // True when position p lies strictly within POCKET_R of centre c.
  function automatic logic near(input logic signed [W-1:0] p, input int c);
    logic signed [W+1:0] d;
    d = {{2{p[W-1]}}, p} - (W+2)'(c);
    return (d < PR_S) && (d > -PR_S);
  endfunction

  // Cooldown step: a pocket clears, a hit arms, an armed counter runs to COOLDOWN then frees.
  function automatic logic [CW-1:0] cd_next(input logic [CW-1:0] cd, input logic hit,
                                            input logic pocket);
    if (pocket)       return '0;
    if (hit)          return CW'(1);
    if (cd == '0)     return '0;
    if (cd == CD_MAX) return '0;
    return cd + 1'b1;
  endfunction

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Scan FSM next state; frame_start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_SCAN;
      ST_SCAN:  if (idx_p0 == LAST_IDX) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Scan FSM outputs.
  always_comb begin
    busy  = (state != ST_IDLE);
    issue = (state == ST_SCAN);
  end

  // Ball index issued into stage 1, one per SCAN cycle.
  always_ff @(posedge clk) begin
    if (reset)      idx_p0 <= '0;
    else if (issue) idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + 1'b1;
  end

  // ---- stage 1: select ball, cooldown lookup, pocket test ----
  always_comb begin
    sel_p0    = int'(idx_p0) * W;
    x_p0      = x_all[sel_p0 +: W];
    y_p0      = y_all[sel_p0 +: W];
    xs_p0     = xs_all[sel_p0 +: W];
    ys_p0     = ys_all[sel_p0 +: W];
    cdx_p0    = cd_x[idx_p0];
    cdy_p0    = cd_y[idx_p0];
    pocket_p0 = 1'b0;
    if (POCKET_EN != 0) begin
      for (int k = 0; k < NUM_POCKETS; k++) begin
        if (near(x_p0, pocket_cx(k, TABLE_WIDTH)) && near(y_p0, pocket_cy(k, TABLE_HEIGHT)))
          pocket_p0 = 1'b1;
      end
    end
  end

  wall_axis_reflect #(
    .W(W), .RADIUS(RADIUS), .LIMIT(TABLE_WIDTH), .DAMP_SHIFT(DAMP_SHIFT)
  ) u_axis_x (
    .pos(x_p0), .spd(xs_p0), .blocked(cdx_p0 != '0), .hit(hitx_p0), .spd_new(xsn_p0)
  );

  wall_axis_reflect #(
    .W(W), .RADIUS(RADIUS), .LIMIT(TABLE_HEIGHT), .DAMP_SHIFT(DAMP_SHIFT)
  ) u_axis_y (
    .pos(y_p0), .spd(ys_p0), .blocked(cdy_p0 != '0), .hit(hity_p0), .spd_new(ysn_p0)
  );

  // Per-ball per-axis cooldown storage, updated as each ball is scanned.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BALLS; b++) begin
        cd_x[b] <= '0;
        cd_y[b] <= '0;
      end
    end else if (issue) begin
      cd_x[idx_p0] <= cd_next(cdx_p0, hitx_p0, pocket_p0);
      cd_y[idx_p0] <= cd_next(cdy_p0, hity_p0, pocket_p0);
    end
  end

  // ---- stage 2: registered results; a pocket overrides any cushion hit ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      done          <= 1'b0;
      out_idx       <= '0;
      out_xspeed    <= '0;
      out_yspeed    <= '0;
      out_collision <= 2'b00;
      out_pocket    <= 1'b0;
    end else begin
      out_valid <= issue;
      done      <= issue && (idx_p0 == LAST_IDX);
      if (issue) begin
        out_idx       <= idx_p0;
        out_xspeed    <= pocket_p0 ? '0 : xsn_p0;
        out_yspeed    <= pocket_p0 ? '0 : ysn_p0;
        out_collision <= pocket_p0 ? 2'b00 : {hitx_p0, hity_p0};
        out_pocket    <= pocket_p0;
      end
    end
  end

endmodule
